shape_sequencer: RTL and testbench

- Controls the splitter. Accepts one 74-bit draw opcode per handshake, holds it stable on the splitter's opdata input, and steps output_sel through the phase codes for the shape.
- Issues one draw_start per phase to the line/circle rasterizer and waits for draw_done before moving to the next phase.
- Reports shape completion, unknown-shape errors and rasterizer timeouts.

---
 rtl/shape_sequencer.sv | 135 +++++++++++++
 tb/tb_shape_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/shape_sequencer.sv
// Shape sequencer: accepts one draw opcode, holds it for the splitter, and walks
// output_sel through the shape's phases while handshaking with the rasterizer.
module shape_sequencer #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int TO_W           = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [3:0]  op_shape,
    input  logic [73:0] op_data,
    output logic [73:0] opdata,
    output logic [3:0]  output_sel,
    output logic        draw_start,
    input  logic        draw_done,
    output logic        busy,
    output logic        shape_done,
    output logic        err_shape,
    output logic        err_timeout
);
    // state  | meaning
    // IDLE   | waiting for an opcode, op_ready high
    // ISSUE  | one-cycle draw_start for the current phase
    // WAIT   | waiting for draw_done, timeout counter running
    // FINISH | one-cycle shape_done
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [3:0] SHAPE_LINE   = 4'b0000;
    localparam logic [3:0] SHAPE_TRI    = 4'b0001;
    localparam logic [3:0] SHAPE_CIRCLE = 4'b0010;

    localparam logic [3:0] SEL_LL1 = 4'b0000;
    localparam logic [3:0] SEL_TL1 = 4'b0001;
    localparam logic [3:0] SEL_CA1 = 4'b0100;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state, state_nx;
    logic [3:0]      shape_q;
    logic [1:0]      phase;
    logic [TO_W-1:0] to_cnt;
    logic            accept;
    logic            shape_ok;
    logic            last_phase;
    logic            timeout_hit;

    assign accept      = op_valid & op_ready;
    assign shape_ok    = (op_shape == SHAPE_LINE) || (op_shape == SHAPE_TRI) ||
                         (op_shape == SHAPE_CIRCLE);
    assign last_phase  = (shape_q == SHAPE_TRI) ? (phase == 2'd2) : 1'b1;
    // to_cnt is 0 on the first WAIT cycle, so this marks the last allowed one
    assign timeout_hit = (to_cnt == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (accept && shape_ok) state_nx = S_ISSUE;
            S_ISSUE:  state_nx = S_WAIT;
            S_WAIT: begin
                if (draw_done)        state_nx = last_phase ? S_FINISH : S_ISSUE;
                else if (timeout_hit) state_nx = S_IDLE;
            end
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        op_ready   = 1'b0;
        busy       = 1'b1;
        draw_start = 1'b0;
        shape_done = 1'b0;
        case (state)
            S_IDLE: begin
                op_ready = 1'b1;
                busy     = 1'b0;
            end
            S_ISSUE:  draw_start = 1'b1;
            S_FINISH: shape_done = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opdata      <= '0;
            shape_q     <= '0;
            output_sel  <= SEL_LL1;
            phase       <= '0;
            to_cnt      <= '0;
            err_shape   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            err_shape   <= (state == S_IDLE) && accept && !shape_ok;
            err_timeout <= (state == S_WAIT) && !draw_done && timeout_hit;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        opdata  <= op_data;
                        shape_q <= op_shape;
                        if (shape_ok) begin
                            phase <= '0;
                            case (op_shape)
                                SHAPE_TRI:    output_sel <= SEL_TL1;
                                SHAPE_CIRCLE: output_sel <= SEL_CA1;
                                default:      output_sel <= SEL_LL1;
                            endcase
                        end
                    end
                end
                S_ISSUE: to_cnt <= '0;
                S_WAIT: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    // triangle phase codes are consecutive, so advance by one
                    if (draw_done && !last_phase) begin
                        phase      <= phase + 2'd1;
                        output_sel <= output_sel + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_shape_sequencer.sv
// Directed bench for shape_sequencer with a short timeout (8 cycles).
module tb_shape_sequencer;
    logic        tb_clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_shape;
    logic [73:0] op_data;
    logic [73:0] opdata;
    logic [3:0]  output_sel;
    logic        draw_start;
    logic        draw_done;
    logic        busy;
    logic        shape_done;
    logic        err_shape;
    logic        err_timeout;

    int checks   = 0;
    int failures = 0;
    int ds_cnt = 0, sd_cnt = 0, es_cnt = 0, et_cnt = 0;
    int ds0, sd0, es0, et0;

    localparam logic [73:0] V_LINE = {16'h000F, 19'h00012, 19'h00003, 19'h00000, 1'b0};
    localparam logic [73:0] V_TRI  = {16'hF800, 19'h01234, 19'h05678, 19'h00ABC, 1'b1};
    localparam logic [73:0] V_CIR  = {16'h07E0, 19'h00400, 19'h00020, 19'h00000, 1'b1};
    localparam logic [73:0] V_L2   = {16'h001F, 19'h7FFFF, 19'h00001, 19'h00002, 1'b0};
    localparam logic [73:0] V_BAD  = {16'hABCD, 19'h11111, 19'h22222, 19'h33333, 1'b1};

    always #5 tb_clk = ~tb_clk;

    shape_sequencer #(.TIMEOUT_CYCLES(8), .TO_W(4)) dut (
        .clk(tb_clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op_shape(op_shape), .op_data(op_data), .opdata(opdata),
        .output_sel(output_sel), .draw_start(draw_start), .draw_done(draw_done),
        .busy(busy), .shape_done(shape_done), .err_shape(err_shape),
        .err_timeout(err_timeout)
    );

    always @(negedge tb_clk) begin
        if (draw_start)  ds_cnt++;
        if (shape_done)  sd_cnt++;
        if (err_shape)   es_cnt++;
        if (err_timeout) et_cnt++;
    end

    task automatic chk(input string tag, input logic [73:0] obs, input logic [73:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge tb_clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 74'(op_ready), 74'd1);
        chk({tag, "_opdata"}, opdata, 74'd0);
        chk({tag, "_sel"}, 74'(output_sel), 74'd0);
        chk({tag, "_pulses"}, 74'({draw_start, busy, shape_done, err_shape, err_timeout}), 74'd0);
    endtask

    task automatic snap();
        ds0 = ds_cnt; sd0 = sd_cnt; es0 = es_cnt; et0 = et_cnt;
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_shape = 4'd0; op_data = '0; draw_done = 1'b0;
        #1;
        chk_reset_vals("por");
        tick(2);
        rst = 1'b0;
        tick(1);
        chk_reset_vals("idle0");

        // reset in the middle of a triangle's second WAIT
        snap();
        op_valid = 1'b1; op_shape = 4'b0001; op_data = V_TRI;
        tick(1); op_valid = 1'b0;
        tick(1); draw_done = 1'b1;
        tick(1); draw_done = 1'b0;
        chk("rst_pre_sel", 74'(output_sel), 74'd2);
        tick(1);
        chk("rst_pre_busy", 74'(busy), 74'd1);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("rst_async");
        tick(2);
        #2 rst = 1'b0;
        draw_done = 1'b1;
        tick(3);
        draw_done = 1'b0;
        chk("rst_post_ready", 74'(op_ready), 74'd1);
        chk("rst_post_busy", 74'(busy), 74'd0);
        chk("rst_no_done", 74'(sd_cnt - sd0), 74'd0);

        // LINE, draw_done two cycles after draw_start
        snap();
        op_valid = 1'b1; op_shape = 4'b0000; op_data = V_LINE;
        tick(1); op_valid = 1'b0;
        chk("line_issue_ds", 74'(draw_start), 74'd1);
        chk("line_sel", 74'(output_sel), 74'd0);
        chk("line_opdata", opdata, V_LINE);
        chk("line_issue_ready", 74'(op_ready), 74'd0);
        tick(1);
        chk("line_wait1_ds", 74'(draw_start), 74'd0);
        tick(1); draw_done = 1'b1;
        tick(1); draw_done = 1'b0;
        chk("line_done", 74'(shape_done), 74'd1);
        tick(1);
        chk("line_done_off", 74'(shape_done), 74'd0);
        chk("line_ready_after", 74'(op_ready), 74'd1);
        chk("line_ds_count", 74'(ds_cnt - ds0), 74'd1);
        chk("line_opdata_hold", opdata, V_LINE);

        // TRIANGLE, draw_done one cycle after each draw_start
        snap();
        op_valid = 1'b1; op_shape = 4'b0001; op_data = V_TRI;
        tick(1); op_valid = 1'b0;
        chk("tri_sel1", 74'(output_sel), 74'd1);
        chk("tri_ds1", 74'(draw_start), 74'd1);
        tick(1); draw_done = 1'b1;
        tick(1); draw_done = 1'b0;
        chk("tri_sel2", 74'(output_sel), 74'd2);
        chk("tri_ds2", 74'(draw_start), 74'd1);
        chk("tri_nodone2", 74'(shape_done), 74'd0);
        chk("tri_opdata2", opdata, V_TRI);
        tick(1); draw_done = 1'b1;
        tick(1); draw_done = 1'b0;
        chk("tri_sel3", 74'(output_sel), 74'd3);
        chk("tri_nodone3", 74'(shape_done), 74'd0);
        tick(1);
        chk("tri_wait3_done", 74'(shape_done), 74'd0);
        draw_done = 1'b1;
        tick(1); draw_done = 1'b0;
        chk("tri_done", 74'(shape_done), 74'd1);
        chk("tri_opdata_end", opdata, V_TRI);
        tick(1);
        chk("tri_ds_count", 74'(ds_cnt - ds0), 74'd3);
        chk("tri_sd_count", 74'(sd_cnt - sd0), 74'd1);
        chk("tri_sel_hold", 74'(output_sel), 74'd3);

        // CIRCLE with op_valid held, second opcode waits for shape_done
        op_valid = 1'b1; op_shape = 4'b0010; op_data = V_CIR;
        tick(1);
        op_shape = 4'b0000; op_data = V_L2;
        chk("cir_sel", 74'(output_sel), 74'd4);
        chk("cir_ready", 74'(op_ready), 74'd0);
        tick(1); draw_done = 1'b1;
        tick(1); draw_done = 1'b0;
        chk("cir_done", 74'(shape_done), 74'd1);
        chk("cir_opdata_held", opdata, V_CIR);
        op_valid = 1'b0;
        tick(1);
        snap();
        draw_done = 1'b1;
        tick(1); draw_done = 1'b0;
        chk("idle_done_busy", 74'(busy), 74'd0);
        chk("idle_done_sel", 74'(output_sel), 74'd4);
        op_valid = 1'b1;
        tick(1); op_valid = 1'b0;
        chk("cir2_opdata", opdata, V_L2);
        chk("cir2_sel", 74'(output_sel), 74'd0);
        tick(1);
        chk("cir2_wait_busy", 74'(busy), 74'd1);
        draw_done = 1'b1;
        tick(1); draw_done = 1'b0;
        chk("cir2_done", 74'(shape_done), 74'd1);
        tick(1);
        chk("cir2_ds_count", 74'(ds_cnt - ds0), 74'd1);

        // unsupported shape code
        snap();
        op_valid = 1'b1; op_shape = 4'b0111; op_data = V_BAD;
        tick(1); op_valid = 1'b0;
        chk("bad_err", 74'(err_shape), 74'd1);
        chk("bad_busy", 74'(busy), 74'd0);
        chk("bad_ready", 74'(op_ready), 74'd1);
        chk("bad_opdata", opdata, V_BAD);
        tick(1);
        chk("bad_err_off", 74'(err_shape), 74'd0);
        chk("bad_counts", 74'({8'(ds_cnt - ds0), 8'(es_cnt - es0), 8'(busy)}), 74'h000100);

        // timeout: draw_done never arrives
        snap();
        op_valid = 1'b1; op_shape = 4'b0000; op_data = V_LINE;
        tick(1); op_valid = 1'b0;
        tick(8);
        chk("to_wait8_busy", 74'(busy), 74'd1);
        chk("to_wait8_et", 74'(err_timeout), 74'd0);
        tick(1);
        chk("to_err", 74'(err_timeout), 74'd1);
        chk("to_err_es", 74'(err_shape), 74'd0);
        chk("to_busy", 74'(busy), 74'd0);
        chk("to_ready", 74'(op_ready), 74'd1);
        tick(1);
        chk("to_err_off", 74'(err_timeout), 74'd0);
        chk("to_counts", 74'({8'(et_cnt - et0), 8'(sd_cnt - sd0)}), 74'h0100);

        // draw_done on the 8th WAIT cycle beats the timeout
        snap();
        op_valid = 1'b1;
        tick(1); op_valid = 1'b0;
        tick(8); draw_done = 1'b1;
        tick(1); draw_done = 1'b0;
        chk("edge_done", 74'(shape_done), 74'd1);
        chk("edge_no_et", 74'(err_timeout), 74'd0);
        tick(1);
        chk("edge_counts", 74'({8'(et_cnt - et0), 8'(sd_cnt - sd0)}), 74'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
